// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Grant rule: a lone requester wins; on a tie the one not served last wins.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   localparam int SERIAL_ADD_WIDTH_DEFAULT = 8;
   localparam int NUM_REQ = 2;

   function automatic logic [NUM_REQ-1:0] rr_grant(
      input logic [NUM_REQ-1:0] v,
      input logic               last
   );
      logic [NUM_REQ-1:0] g;
      g = v;
      if (v == 2'b11)
         g = last ? 2'b01 : 2'b10;
      return g;
   endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder; the only arithmetic cell of the serial adder.
// Purely combinational.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Round-robin shared bit-serial adder, LSB first, one op in flight.
// Optional SERIAL_ADD_OVF_EN adds the two's-complement res_ovf output.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0][WIDTH-1:0] req_a,
   input  logic [1:0][WIDTH-1:0] req_b,
   input  logic [1:0]            req_cin,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_sum,
   output logic                  res_cout,
   output logic                  res_id
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic                  res_ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cout_r;
   logic             last;
   logic [1:0]       grant;
   logic             fa_s;
   logic             fa_co;

   always_comb grant = rr_grant(req_valid, last);

   assign req_ready = (state == IDLE) ? grant : 2'b00;

   fa_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_co)
   );

   // Result registers are only exposed while the result is offered.
   assign res_valid = (state == DONE);
   assign res_sum   = res_valid ? sum_sr : '0;
   assign res_cout  = res_valid & cout_r;

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_r;
   assign res_ovf = res_valid & ovf_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ovf_r <= 1'b0;
      else if (state == ADD && cnt == CW'(WIDTH - 1))
         ovf_r <= carry ^ fa_co;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         res_id <= 1'b0;
         last   <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (|grant) begin
                  a_sr   <= req_a[grant[1]];
                  b_sr   <= req_b[grant[1]];
                  carry  <= req_cin[grant[1]];
                  res_id <= grant[1];
                  last   <= grant[1];
                  cnt    <= '0;
                  state  <= ADD;
               end
            end
            ADD: begin
               sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               carry  <= fa_co;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  cout_r <= fa_co;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (res_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed literal cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic              clk;
   logic              reset;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][W-1:0] req_a;
   logic [1:0][W-1:0] req_b;
   logic [1:0]        req_cin;
   logic              res_valid;
   logic              res_ready;
   logic [W-1:0]      res_sum;
   logic              res_cout;
   logic              res_id;
   logic              ovf_w;

   int errors = 0;
   int checks = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .res_ovf   (ovf_w)
`endif
   );

`ifndef SERIAL_ADD_OVF_EN
   assign ovf_w = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] pick(input logic [1:0] v,
                                       input logic last);
      if (v == 2'b11)
         return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   function automatic logic ovf_of(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic [W-1:0] s);
      return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
   endfunction

   // Transaction model: 0 idle, 1 computing (m_rem edges left), 2 offered
   int           m_phase = 0;
   int           m_rem = 0;
   logic         m_last = 1'b1;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;
   logic         m_id = 1'b0;
   logic         m_ovf = 1'b0;

   always @(negedge clk) begin
      logic [1:0] er;
      logic       g;
      logic [W:0] tot;
      if (reset) begin
         chk("rst_ready", {30'd0, req_ready}, {30'd0, pick(req_valid, 1'b1)});
         chk("rst_valid", {31'd0, res_valid}, 32'd0);
         chk("rst_sum", {24'd0, res_sum}, 32'd0);
         chk("rst_cout", {31'd0, res_cout}, 32'd0);
         chk("rst_id", {31'd0, res_id}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
         chk("rst_ovf", {31'd0, ovf_w}, 32'd0);
`endif
         m_phase = 0;
         m_last  = 1'b1;
      end else begin
         er = (m_phase == 0) ? pick(req_valid, m_last) : 2'b00;
         chk("ready", {30'd0, req_ready}, {30'd0, er});
         chk("valid", {31'd0, res_valid}, {31'd0, m_phase == 2});
         chk("sum", {24'd0, res_sum},
             {24'd0, (m_phase == 2) ? m_sum : 8'h00});
         chk("cout", {31'd0, res_cout}, {31'd0, (m_phase == 2) && m_cout});
         if (m_phase == 2)
            chk("id", {31'd0, res_id}, {31'd0, m_id});
`ifdef SERIAL_ADD_OVF_EN
         chk("ovf", {31'd0, ovf_w}, {31'd0, (m_phase == 2) && m_ovf});
`endif
         case (m_phase)
            0: if (er != 2'b00) begin
               g = er[1];
               tot = {1'b0, req_a[g]} + {1'b0, req_b[g]} +
                     {{W{1'b0}}, req_cin[g]};
               m_sum   = tot[W-1:0];
               m_cout  = tot[W];
               m_ovf   = ovf_of(req_a[g], req_b[g], tot[W-1:0]);
               m_id    = g;
               m_last  = g;
               m_rem   = W;
               m_phase = 1;
            end
            1: begin
               m_rem--;
               if (m_rem == 0)
                  m_phase = 2;
            end
            default: if (res_ready) m_phase = 0;
         endcase
      end
   end

   task automatic issue(input logic [1:0] mask,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic c0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic c1, input logic [1:0] exp_g);
      bit ok;
      ok = 0;
      req_a[0] = a0; req_b[0] = b0; req_cin[0] = c0;
      req_a[1] = a1; req_b[1] = b1; req_cin[1] = c1;
      req_valid = mask;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (|(req_ready & req_valid)) begin
            ok = 1;
            break;
         end
      end
      chk("issue_accepted", {31'd0, ok}, 32'd1);
      chk("grant", {30'd0, req_ready}, {30'd0, exp_g});
      @(posedge clk);
      #1;
      req_valid = 2'b00;
   endtask

   task automatic wait_res(input logic [W-1:0] es, input logic ec,
                           input logic eid, input logic eo,
                           input bit hold);
      int n;
      logic [W-1:0] s0;
      n = 0;
      res_ready = hold ? 1'b0 : 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (res_valid) break;
      end
      chk("latency_edges", n - 1, W);
      chk("lit_sum", {24'd0, res_sum}, {24'd0, es});
      chk("lit_cout", {31'd0, res_cout}, {31'd0, ec});
      chk("lit_id", {31'd0, res_id}, {31'd0, eid});
      chk("model_sum", {24'd0, m_sum}, {24'd0, es});
`ifdef SERIAL_ADD_OVF_EN
      chk("lit_ovf", {31'd0, ovf_w}, {31'd0, eo});
`else
      if (eo === 1'bx) chk("ovf_arg", 0, 1);
`endif
      if (hold) begin
         s0 = res_sum;
         @(posedge clk);
         #1;
         req_valid = 2'b11;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_sum", {24'd0, res_sum}, {24'd0, s0});
            chk("hold_ready", {30'd0, req_ready}, 32'd0);
         end
         @(posedge clk);
         #1;
         res_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      chk("valid_drop", {31'd0, res_valid}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] a0, b0, a1, b1, s;
      logic [W:0]   t;
      logic         c0, c1, gid;
      reset = 1'b1;
      req_valid = 2'b01;
      req_a = '0;
      req_b = '0;
      req_cin = 2'b00;
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_lit_ready", {30'd0, req_ready}, 32'd1);
      chk("rst_lit_valid", {31'd0, res_valid}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 2'b00;

      issue(2'b01, 8'h0F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 2'b01);
      wait_res(8'h10, 1'b0, 1'b0, 1'b0, 0);
      issue(2'b10, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, 2'b10);
      wait_res(8'h00, 1'b1, 1'b1, 1'b0, 0);

      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      issue(2'b11, 8'h7F, 8'h01, 1'b0, 8'h12, 8'h34, 1'b0, 2'b01);
      wait_res(8'h80, 1'b0, 1'b0, 1'b1, 0);
      for (int k = 0; k < 5; k++) begin
         a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom);
         a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
         gid = (k % 2 == 0);
         t = gid ? ({1'b0, a1} + {1'b0, b1} + {8'd0, c1})
                 : ({1'b0, a0} + {1'b0, b0} + {8'd0, c0});
         s = t[W-1:0];
         issue(2'b11, a0, b0, c0, a1, b1, c1, gid ? 2'b10 : 2'b01);
         wait_res(s, t[W], gid,
                  gid ? ovf_of(a1, b1, s) : ovf_of(a0, b0, s), 0);
      end

      issue(2'b01, 8'hC8, 8'h64, 1'b1, 8'h00, 8'h00, 1'b0, 2'b01);
      wait_res(8'h2D, 1'b1, 1'b0, 1'b0, 1);

      issue(2'b01, 8'h55, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b0, 2'b01);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      req_valid = 2'b10;
      #1;
      chk("midrst_valid", {31'd0, res_valid}, 32'd0);
      chk("midrst_idle", {30'd0, req_ready}, 32'd2);
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 2'b00;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk("no_dropped_result", {31'd0, res_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      issue(2'b01, 8'h3C, 8'h0D, 1'b1, 8'h00, 8'h00, 1'b0, 2'b01);
      wait_res(8'h4A, 1'b0, 1'b0, 1'b0, 0);

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         reset = ($urandom_range(0, 249) == 0);
         req_valid = 2'($urandom);
         req_a = 16'($urandom);
         req_b = 16'($urandom);
         req_cin = 2'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
